key_direction_ctrl: RTL

KEY_DIRECTION_CTRL -- requirements
Module: key_direction_ctrl

---
 rtl/key_direction_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/key_direction_ctrl.sv
// Snake-game key handler: button edge detect, pause toggle, pending direction applied on game_tick; auto-repeat under KEY_AUTOREPEAT_EN.
// Latency: press_valid 2 clk edges after first sample of a pressed button; dir_out updates on the game_tick edge.
// Backpressure: none; events are pulses, a newer pending direction overwrites an unconsumed one.
module key_direction_ctrl #(
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       middle,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       game_tick,
    output logic       press_valid,
    output logic [2:0] press_code,
    output logic [1:0] dir_out,
    output logic       dir_changed,
    output logic       paused
);

    logic [4:0] keys;
    logic [4:0] s;
    logic [4:0] p;
    logic [4:0] rise;
    logic       ev_vld;
    logic [2:0] ev_code;
    logic       key_vld;
    logic [2:0] key_code;
    logic [1:0] key_dir;
    logic       pend_valid;
    logic [1:0] pend_dir;

    // Bit index equals press_code, so the lowest set bit has the highest priority.
    assign keys = {right, left, down, up, middle};
    assign rise = s & ~p;

    always_comb begin
        ev_vld  = 1'b0;
        ev_code = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (rise[i]) begin
                ev_vld  = 1'b1;
                ev_code = 3'(i);
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(RMAX + 1);

    logic [CW-1:0] rpt_cnt;
    logic          rpt_armed;
    logic          held_one;
    logic          rpt_fire;
    logic [2:0]    rpt_code;

    assign held_one = (s[4:1] != 4'd0) && ((s[4:1] & (s[4:1] - 4'd1)) == 4'd0);
    assign rpt_fire = !ev_vld && held_one &&
                      (rpt_cnt == (rpt_armed ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1)));

    always_comb begin
        rpt_code = 3'd1;
        for (int i = 4; i >= 1; i--) begin
            if (s[i]) begin
                rpt_code = 3'(i);
            end
        end
    end

    // Counting restarts on every fresh edge and whenever the single held key is not alone.
    always_ff @(posedge clk) begin
        if (rst || ev_vld || !held_one) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + CW'(1);
        end
    end

    assign key_vld  = ev_vld | rpt_fire;
    assign key_code = ev_vld ? ev_code : rpt_code;
`else
    assign key_vld  = ev_vld;
    assign key_code = ev_code;
`endif

    // Codes 1..4 map onto directions 0..3.
    assign key_dir = key_code[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s           <= 5'd0;
            p           <= 5'd0;
            press_valid <= 1'b0;
            press_code  <= 3'd0;
            dir_out     <= 2'd3;
            dir_changed <= 1'b0;
            paused      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_dir    <= 2'd0;
        end else begin
            s           <= keys;
            p           <= s;
            press_valid <= key_vld;
            dir_changed <= 1'b0;
            if (key_vld) begin
                press_code <= key_code;
            end
            // Reverse check uses dir_out at tick time; same axis means same or reverse.
            if (game_tick && !paused && pend_valid) begin
                pend_valid <= 1'b0;
                if (pend_dir[1] != dir_out[1]) begin
                    dir_out     <= pend_dir;
                    dir_changed <= 1'b1;
                end
            end
            // Placed after the tick so a coinciding event becomes pending for the next tick.
            if (key_vld) begin
                if (key_code == 3'd0) begin
                    paused <= !paused;
                    if (!paused) begin
                        pend_valid <= 1'b0;
                    end
                end else if (!paused) begin
                    pend_valid <= 1'b1;
                    pend_dir   <= key_dir;
                end
            end
        end
    end

endmodule
